// File: rtl/regfile_pkg.sv
// Shared defaults and index type for the scoreboarded register file.
package regfile_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int LED_REG   = 11;

    typedef logic [$clog2(NREGS_DEF)-1:0] reg_idx_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with reservation grant and per-read-port busy flags.
// REGFILE_BYPASS_EN: a same-cycle writeback masks rd_busy for the matching port.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic            rsv_ok,
    output logic [NRD-1:0]  rd_busy
);
    logic [NREGS-1:0] busy;
    logic             rsv_set;

    // A writeback landing on the reserved index frees it this very cycle.
    assign rsv_ok  = (rsv_addr == '0) || !busy[rsv_addr] || (wr_en && wr_addr == rsv_addr);
    assign rsv_set = rsv_en && rsv_ok && (rsv_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (rsv_set && rsv_addr == AW'(r))
                    busy[r] <= 1'b1;
                else if (wr_en && wr_addr == AW'(r))
                    busy[r] <= 1'b0;
            end
            busy[0] <= 1'b0;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] idx;
        logic          wr_hit;
        assign idx = rd_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign wr_hit = wr_en && (wr_addr == idx);
`else
        assign wr_hit = 1'b0;
`endif
        assign rd_busy[i] = busy[idx] && (idx != '0) && !wr_hit;
    end
endmodule

// File: rtl/regfile_sb.sv
// Register file with NRD combinational read ports, one writeback port and a busy scoreboard.
// REGFILE_BYPASS_EN: reads of the index being written return write_port in the same cycle.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_rd_en,
    input  logic [AW-1:0]     addr_wr,
    input  logic [XLEN-1:0]   write_port,
    input  logic [NRD*AW-1:0] addr_rd,
    output logic [NRD*XLEN-1:0] read_port,
    output logic [NRD-1:0]    rd_busy,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    output logic              rsv_ok,
    output logic              led
);
    logic [XLEN-1:0] regs [NREGS];
    logic            wr_fire;

    assign wr_fire = wr_rd_en && (addr_wr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else if (wr_fire) begin
            regs[addr_wr] <= write_port;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] idx;
        assign idx = addr_rd[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        assign read_port[i*XLEN +: XLEN] = (idx == '0)                    ? '0 :
                                           (wr_fire && addr_wr == idx)    ? write_port :
                                                                            regs[idx];
`else
        assign read_port[i*XLEN +: XLEN] = (idx == '0) ? '0 : regs[idx];
`endif
    end

    // Debug flag looks only at stored state; small configs without LED_REG tie it low.
    if (LED_REG < NREGS) begin : g_led
        assign led = (regs[LED_REG] == XLEN'(1));
    end else begin : g_no_led
        assign led = 1'b0;
    end

    regfile_scoreboard #(.NREGS(NREGS), .NRD(NRD), .AW(AW)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_rd_en),
        .wr_addr  (addr_wr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_addr  (addr_rd),
        .rsv_ok   (rsv_ok),
        .rd_busy  (rd_busy)
    );
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb (XLEN=32, NREGS=32, NRD=2); follows REGFILE_BYPASS_EN if defined.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_rd_en;
    logic [4:0]  addr_wr;
    logic [31:0] write_port;
    logic [9:0]  addr_rd;
    logic [63:0] read_port;
    logic [1:0]  rd_busy;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        rsv_ok;
    logic        led;

    int checks = 0;
    int errors = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_rd_en   (wr_rd_en),
        .addr_wr    (addr_wr),
        .write_port (write_port),
        .addr_rd    (addr_rd),
        .read_port  (read_port),
        .rd_busy    (rd_busy),
        .rsv_en     (rsv_en),
        .rsv_addr   (rsv_addr),
        .rsv_ok     (rsv_ok),
        .led        (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        addr_rd = {a1, a0};
        #1;
    endtask

    initial begin
        rst = 1'b1; wr_rd_en = 1'b0; addr_wr = '0; write_port = '0;
        addr_rd = '0; rsv_en = 1'b0; rsv_addr = '0;
        tick();
        rst = 1'b0;
        rd(5'd5, 5'd7);
        rsv_addr = 5'd7; #1;
        chk("rst_rp0", read_port[31:0], 32'h0);
        chk("rst_rp1", read_port[63:32], 32'h0);
        chk("rst_busy", {30'd0, rd_busy}, 32'h0);
        chk("rst_led", {31'd0, led}, 32'h0);
        chk("rst_rsv_ok", {31'd0, rsv_ok}, 32'h1);

        // write x5, read on both ports
        wr_rd_en = 1'b1; addr_wr = 5'd5; write_port = 32'hDEADBEEF;
        tick();
        wr_rd_en = 1'b0;
        rd(5'd5, 5'd5);
        chk("x5_p0", read_port[31:0], 32'hDEADBEEF);
        chk("x5_p1", read_port[63:32], 32'hDEADBEEF);

        // x0 ignores writes; reservation of x0 granted and no busy
        wr_rd_en = 1'b1; addr_wr = 5'd0; write_port = 32'h1234;
        rsv_en = 1'b1; rsv_addr = 5'd0; #1;
        chk("x0_rsv_ok", {31'd0, rsv_ok}, 32'h1);
        tick();
        wr_rd_en = 1'b0; rsv_en = 1'b0;
        rd(5'd0, 5'd5);
        chk("x0_read", read_port[31:0], 32'h0);
        chk("x0_busy", {31'd0, rd_busy[0]}, 32'h0);

        // reserve x7
        rsv_en = 1'b1; rsv_addr = 5'd7; #1;
        chk("rsv7_ok", {31'd0, rsv_ok}, 32'h1);
        tick();
        rsv_en = 1'b0;
        rd(5'd5, 5'd7);
        chk("rsv7_busy", {30'd0, rd_busy}, 32'h2);
        rsv_en = 1'b1; #1;
        chk("rsv7_again_ok", {31'd0, rsv_ok}, 32'h0);
        tick();
        rsv_en = 1'b0; #1;
        chk("rsv7_refused_busy", {31'd0, rd_busy[1]}, 32'h1);

        // writeback x7 clears busy
        wr_rd_en = 1'b1; addr_wr = 5'd7; write_port = 32'h55; #1;
        chk("wb7_samecyc_busy", {31'd0, rd_busy[1]}, BYP ? 32'h0 : 32'h1);
        chk("wb7_samecyc_data", read_port[63:32], BYP ? 32'h55 : 32'h0);
        tick();
        wr_rd_en = 1'b0; #1;
        chk("wb7_busy", {31'd0, rd_busy[1]}, 32'h0);
        chk("wb7_data", read_port[63:32], 32'h55);

        // re-reserve x7, then same-cycle write + reserve: set wins
        rsv_en = 1'b1; rsv_addr = 5'd7;
        tick();
        chk("rsv7b_busy", {31'd0, rd_busy[1]}, 32'h1);
        wr_rd_en = 1'b1; addr_wr = 5'd7; write_port = 32'h77; #1;
        chk("wr_rsv_ok", {31'd0, rsv_ok}, 32'h1);
        tick();
        wr_rd_en = 1'b0; rsv_en = 1'b0; #1;
        chk("wr_rsv_busy", {31'd0, rd_busy[1]}, 32'h1);
        chk("wr_rsv_data", read_port[63:32], 32'h77);
        wr_rd_en = 1'b1; write_port = 32'h78;
        tick();
        wr_rd_en = 1'b0; #1;
        chk("wr7_clear_busy", {31'd0, rd_busy[1]}, 32'h0);

        // write to a non-busy register leaves it non-busy
        wr_rd_en = 1'b1; addr_wr = 5'd3; write_port = 32'h11;
        tick();
        rd(5'd3, 5'd7);
        chk("x3_nobusy", {31'd0, rd_busy[0]}, 32'h0);
        addr_wr = 5'd3; write_port = 32'hA5; #1;
        chk("x3_samecyc", read_port[31:0], BYP ? 32'hA5 : 32'h11);
        tick();
        wr_rd_en = 1'b0; #1;
        chk("x3_next", read_port[31:0], 32'hA5);

        // led tracks x11 == 1
        wr_rd_en = 1'b1; addr_wr = 5'd11; write_port = 32'h1; #1;
        chk("led_before", {31'd0, led}, 32'h0);
        tick();
        wr_rd_en = 1'b0; #1;
        chk("led_on", {31'd0, led}, 32'h1);
        wr_rd_en = 1'b1; write_port = 32'h2;
        tick();
        wr_rd_en = 1'b0; #1;
        chk("led_off", {31'd0, led}, 32'h0);

        // reserve x9 then reset; reset also ignores a concurrent write
        rsv_en = 1'b1; rsv_addr = 5'd9;
        tick();
        rsv_en = 1'b0;
        rd(5'd9, 5'd5);
        chk("rsv9_busy", {31'd0, rd_busy[0]}, 32'h1);
        rst = 1'b1; wr_rd_en = 1'b1; addr_wr = 5'd5; write_port = 32'hCAFE;
        rsv_en = 1'b1; rsv_addr = 5'd12;
        tick();
        rst = 1'b0; wr_rd_en = 1'b0; rsv_en = 1'b0; rsv_addr = 5'd9; #1;
        chk("rst9_busy", {31'd0, rd_busy[0]}, 32'h0);
        chk("rst_x5", read_port[63:32], 32'h0);
        chk("rst_rsv9_ok", {31'd0, rsv_ok}, 32'h1);
        rd(5'd12, 5'd5);
        chk("rst_rsv12_ignored", {31'd0, rd_busy[0]}, 32'h0);

        // writeback after reset lands normally
        wr_rd_en = 1'b1; addr_wr = 5'd9; write_port = 32'h99;
        tick();
        wr_rd_en = 1'b0;
        rd(5'd9, 5'd9);
        chk("post_rst_wb", read_port[31:0], 32'h99);
        chk("post_rst_busy", {30'd0, rd_busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width in bits of every register and data port.
REQ-002 Parameter NREGS, default 32, register count, power of two; AW = $clog2(NREGS).
REQ-003 Parameter NRD, default 2, number of independent read ports, range 1..4.
REQ-004 Port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  in  1  synchronous active-high reset, sampled on rising edge of clk.
REQ-006 Port wr_rd_en  in  1  writeback strobe.
REQ-007 Port addr_wr  in  AW  writeback register index.
REQ-008 Port write_port  in  XLEN  writeback data.
REQ-009 Port addr_rd  in  NRD*AW  packed read indices, port i at bits [i*AW +: AW].
REQ-010 Port read_port  out  NRD*XLEN  packed read data, same packing.
REQ-011 Port rd_busy  out  NRD  per-port flag: addressed register has a pending write.
REQ-012 Port rsv_en  in  1  issue-stage request to reserve a destination register.
REQ-013 Port rsv_addr  in  AW  register index to reserve.
REQ-014 Port rsv_ok  out  1  combinational grant for the current rsv_en request.
REQ-015 Port led  out  1  debug flag, high when register LED_REG holds value 1.

Function
REQ-016 Register 0 SHALL read as 0 on every port; writes and reservations to index 0 are ignored; rsv_ok=1 for index 0.
REQ-017 Writes SHALL occur on the rising edge when wr_rd_en=1 and addr_wr!=0; new value is visible from the next cycle.
REQ-018 Reads SHALL be combinational, zero latency, all NRD ports independent, any ports may alias the same index.
REQ-019 Scoreboard: one busy bit per register; busy[r] set on edge when rsv_en=1, rsv_ok=1, rsv_addr=r!=0.
REQ-020 busy[r] cleared on edge when wr_rd_en=1 and addr_wr=r, unless the same edge sets it (set wins; register data still written).
REQ-021 rsv_ok SHALL be 0 when busy[rsv_addr]=1 and no same-cycle write to rsv_addr clears it; refused requests change no state.
REQ-022 rd_busy[i] = busy[addr_rd[i]], masked to 0 for index 0.
REQ-023 A write to a register not busy SHALL still update data and leave busy at 0.
REQ-024 led = 1 iff register LED_REG equals exactly 1 (zero-extended compare); registered-state only, no bypass.

Reset
REQ-025 On rst=1 at an edge: all registers := 0, all busy := 0; wr_rd_en and rsv_en are ignored in that cycle.
REQ-026 After reset: read_port all 0, rd_busy all 0, led=0, rsv_ok=1.
REQ-027 Reset mid-operation discards all outstanding reservations; a writeback arriving after reset writes data normally.

Configuration
REQ-028 Macro REGFILE_BYPASS_EN: when defined, a read port whose index equals addr_wr (!=0) with wr_rd_en=1 SHALL return write_port the same cycle and its rd_busy SHALL be 0 (unless rsv re-sets it only from next cycle).
REQ-029 Without REGFILE_BYPASS_EN, reads return registered contents only; same-cycle write visible next cycle; rd_busy reflects registered busy.

Structure
REQ-030 Package regfile_pkg SHALL hold default XLEN, default NREGS, LED_REG = 11, and reg-index typedef.
REQ-031 Sub-module regfile_scoreboard SHALL hold busy bits, rsv_ok and rd_busy logic; data array stays in regfile_sb.

Verification
REQ-032 rst=1 one cycle -> all read_port 0, rd_busy 0, led 0, rsv_ok 1.
REQ-033 Write 0xDEADBEEF to x5, next cycle read x5 on both ports -> 0xDEADBEEF both; write 0x1234 to x0 -> x0 reads 0.
REQ-034 Reserve x7 -> rd_busy=1 on port reading x7; reserve x7 again -> rsv_ok=0; write x7=0x55 -> busy cleared next cycle, data 0x55.
REQ-035 Same cycle write x7 and reserve x7 (busy) -> rsv_ok=1, busy stays 1, x7 holds new data.
REQ-036 With REGFILE_BYPASS_EN write x3=0xA5 while reading x3 -> read_port 0xA5 same cycle; without -> old value, 0xA5 next cycle.
REQ-037 Write x11=1 -> led=1 next cycle; write x11=2 -> led=0; reserve x9 then rst -> rd_busy x9 = 0.
